mux2_rr_arbiter: RTL

- Two-requester round-robin arbiter that owns the select of a shared 2:1 data mux.
- Grants one requester at a time, drives the mux select from the grant, and registers the selected data with a valid strobe.
- Sits in front of any single-consumer path fed by two producers.
- Bounded hold time prevents one requester from starving the other.

---
 rtl/mux2_rr_arbiter_if.sv | 35 +++
 rtl/mux2_rr_arbiter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/mux2_rr_arbiter_if.sv
// Handshake/data bundle between two producers and the 2:1 round-robin arbiter.
// Optional grant counters are present only when MUX2_ARB_STATS_EN is defined.
interface mux2_rr_arbiter_if #(
  parameter int DATA_W = 8
);
  logic [1:0]        req;
  logic [DATA_W-1:0] din0;
  logic [DATA_W-1:0] din1;
  logic [1:0]        gnt;
  logic              sel;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
`ifdef MUX2_ARB_STATS_EN
  logic [15:0]       gnt_cnt0;
  logic [15:0]       gnt_cnt1;

  modport master (
    output req, din0, din1,
    input  gnt, sel, dout, dout_valid, gnt_cnt0, gnt_cnt1
  );
  modport slave (
    input  req, din0, din1,
    output gnt, sel, dout, dout_valid, gnt_cnt0, gnt_cnt1
  );
`else
  modport master (
    output req, din0, din1,
    input  gnt, sel, dout, dout_valid
  );
  modport slave (
    input  req, din0, din1,
    output gnt, sel, dout, dout_valid
  );
`endif
endinterface

// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin arbiter driving a shared 2:1 data mux with bounded hold.
// Define MUX2_ARB_STATS_EN to add saturating per-requester beat counters.
module mux2_rr_arbiter #(
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4
) (
  input logic              clk,
  input logic              rst_n,
  mux2_rr_arbiter_if.slave bus
);

  localparam int              HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  // State encoding doubles as the one-hot grant vector.
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_G0   = 2'b01;
  localparam logic [1:0] S_G1   = 2'b10;

  generate
    if (MAX_HOLD < 1) begin : g_bad_hold
      $error("mux2_rr_arbiter: MAX_HOLD must be >= 1");
    end
  endgenerate

  logic [1:0]        r_state;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_last;
  logic [DATA_W-1:0] r_dout;
  logic              r_dout_valid;

  logic [1:0]        w_next_state;
  logic [HOLD_W-1:0] w_next_hold;
  logic              w_sel;
  logic              w_own_req;
  logic              w_other_req;
  logic [1:0]        w_other_state;
  logic              w_xfer;
  logic [DATA_W-1:0] w_data;

  assign w_sel         = r_state[1];
  assign w_own_req     = w_sel ? bus.req[1] : bus.req[0];
  assign w_other_req   = w_sel ? bus.req[0] : bus.req[1];
  assign w_other_state = w_sel ? S_G0 : S_G1;
  assign w_data        = w_sel ? bus.din1 : bus.din0;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    w_next_state = r_state;
    w_next_hold  = r_hold_cnt;
    w_xfer       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_next_hold = '0;
        if (bus.req == 2'b11)  w_next_state = r_last ? S_G0 : S_G1;
        else if (bus.req[0])   w_next_state = S_G0;
        else if (bus.req[1])   w_next_state = S_G1;
      end
      S_G0, S_G1: begin
        if (!w_own_req) begin
          w_next_hold  = '0;
          w_next_state = w_other_req ? w_other_state : S_IDLE;
        end else begin
          w_xfer = 1'b1;
          if (r_hold_cnt == HOLD_LAST) begin
            // Final beat of the hold window: hand over only if the other side waits.
            w_next_hold = '0;
            if (w_other_req) w_next_state = w_other_state;
          end else begin
            w_next_hold = r_hold_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_hold  = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_hold_cnt   <= '0;
      r_last       <= 1'b1;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_hold_cnt   <= w_next_hold;
      r_dout_valid <= w_xfer;
      if (w_next_state != S_IDLE) r_last <= w_next_state[1];
      if (w_xfer)                 r_dout <= w_data;
    end
  end

  assign bus.gnt        = r_state;
  assign bus.sel        = r_state[1];
  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;

`ifdef MUX2_ARB_STATS_EN
  logic [15:0] r_gnt_cnt0;
  logic [15:0] r_gnt_cnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt_cnt0 <= '0;
      r_gnt_cnt1 <= '0;
    end else if (w_xfer) begin
      if (!w_sel && r_gnt_cnt0 != 16'hFFFF) r_gnt_cnt0 <= r_gnt_cnt0 + 16'd1;
      if ( w_sel && r_gnt_cnt1 != 16'hFFFF) r_gnt_cnt1 <= r_gnt_cnt1 + 16'd1;
    end
  end

  assign bus.gnt_cnt0 = r_gnt_cnt0;
  assign bus.gnt_cnt1 = r_gnt_cnt1;
`endif

endmodule
